viterbi_frame_ctrl: RTL and testbench

Frame sequencer for the Viterbi decoder datapath. It collects one frame of eight 8-bit soft samples (r1..r8) from an upstream stream and holds them stable on the datapath inputs. It pulses a start strobe and waits the fixed pipeline latency of the trellis and final stages. It then captures the decoded codeword and shortest-path metric and presents them downstream under a valid/ready handshake.

---
 rtl/viterbi_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_frame_ctrl
//   Frame sequencer for the Viterbi decoder datapath. Collects FRAME_LEN soft
//   samples from an upstream valid/ready stream, holds them on dp_r, fires a
//   one-cycle dp_start, waits DP_LATENCY cycles for the trellis/final stages,
//   then captures the decoded codeword and path metric and offers them
//   downstream under a valid/ready handshake.
//
// Ports
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   in_sample/valid/last/ready   upstream sample stream (ready only in LOAD)
//   dp_r              frame samples, r1 in the lowest SAMPLE_W bits
//   dp_start          one-cycle datapath launch strobe
//   dp_codeword/metric datapath results, sampled DP_LATENCY cycles after start
//   out_codeword/metric/valid/ready   captured result and downstream handshake
//   busy              high while a frame is being processed (RUN/WAIT/HOLD)
//   frame_err         registered one-cycle pulse on a framing error
//   frame_cnt         completed output handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module viterbi_frame_ctrl #(
    parameter int SAMPLE_W   = 8,
    parameter int FRAME_LEN  = 8,
    parameter int DP_LATENCY = 6
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [SAMPLE_W-1:0]           in_sample,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [FRAME_LEN*SAMPLE_W-1:0] dp_r,
    output logic                          dp_start,
    input  logic [7:0]                    dp_codeword,
    input  logic [SAMPLE_W-1:0]           dp_metric,
    output logic [7:0]                    out_codeword,
    output logic [SAMPLE_W-1:0]           out_metric,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          frame_err,
    output logic [15:0]                   frame_cnt
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [7:0]       LAT_INIT = 8'(DP_LATENCY - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [7:0]       lat_cnt;
    logic             accept;
    logic             capture;
    logic             handshake;

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state and combinational outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        dp_start   = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        capture    = 1'b0;
        handshake  = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                accept   = in_valid;
                if (in_valid && (idx == LAST_IDX)) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                dp_start   = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_valid && out_ready) begin
                    handshake  = 1'b1;
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Sample buffer, latency counter, result capture and status
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx          <= '0;
            dp_r         <= '0;
            lat_cnt      <= '0;
            out_codeword <= '0;
            out_metric   <= '0;
            out_valid    <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            frame_err <= 1'b0;
            // Written every cycle so the count is always re-derived from its
            // current value.
            frame_cnt <= frame_cnt + 16'(handshake);

            if (accept) begin
                for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                    if (idx == IDX_W'(i)) begin
                        dp_r[i*SAMPLE_W +: SAMPLE_W] <= in_sample;
                    end
                end
                if (idx == LAST_IDX) begin
                    // Full frame proceeds; a missing end marker is only flagged.
                    idx       <= '0;
                    frame_err <= !in_last;
                end else if (in_last) begin
                    // Short frame: discard and restart at slot 0.
                    idx       <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end

            if (state == S_RUN) begin
                lat_cnt <= LAT_INIT;
            end else if ((state == S_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 8'd1;
            end

            if (capture) begin
                out_codeword <= dp_codeword;
                out_metric   <= dp_metric;
                out_valid    <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_viterbi_frame_ctrl
//   Self-checking bench for viterbi_frame_ctrl: a vector table for the
//   sample-loading sequences, hand-written multi-cycle corner cases, and a
//   randomized phase checked against a timestamp-based reference model.
// ---------------------------------------------------------------------------
module tb_viterbi_frame_ctrl;

    localparam int SW = 8;
    localparam int FL = 8;
    localparam int L  = 6;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [SW-1:0] in_sample;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [FL*SW-1:0] dp_r;
    logic          dp_start;
    logic [7:0]    dp_codeword;
    logic [SW-1:0] dp_metric;
    logic [7:0]    out_codeword;
    logic [SW-1:0] out_metric;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    viterbi_frame_ctrl #(
        .SAMPLE_W  (SW),
        .FRAME_LEN (FL),
        .DP_LATENCY(L)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .dp_r        (dp_r),
        .dp_start    (dp_start),
        .dp_codeword (dp_codeword),
        .dp_metric   (dp_metric),
        .out_codeword(out_codeword),
        .out_metric  (out_metric),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_r = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Inputs change at negedge; outputs are sampled at the following negedge.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic frame8(input logic [63:0] data, input logic last8,
                          output int errs, output logic start_seen);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_sample = data[i*8 +: 8];
            in_last   = (i == 7) && last8;
            step();
            exp_r[i*8 +: 8] = data[i*8 +: 8];
            if (frame_err) errs++;
        end
        start_seen = dp_start;
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic wait_valid(output int k, output int starts);
        k = -1;
        starts = 0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (dp_start) starts++;
            if (out_valid) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] s;
        logic       last;
        logic       e_err;
        logic       e_start;
        logic       e_ready;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int   k, starts, errs, acc, cyc;
        logic st;
        int   vcyc[$];
        // model state for the randomized phase
        int   n, e, t_last, in_frame;
        logic err_exp, err_n, exp_valid;
        logic [7:0]  exp_cw, exp_mt;
        logic [15:0] cnt;

        tbl[0]  = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{8'h10, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{8'h05, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{8'hEE, 1'b1, 1'b0, 1'b1, 1'b0};

        RST_N = 1'b0;
        in_sample = '0; in_valid = 1'b0; in_last = 1'b0;
        dp_codeword = '0; dp_metric = '0; out_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dp_r", dp_r, 0);
        chk("rst_dp_start", dp_start, 0);
        chk("rst_out_cw", out_codeword, 0);
        chk("rst_out_mt", out_metric, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Early end marker on the 3rd sample, then the nominal frame.
        for (int i = 0; i < 11; i++) begin
            in_valid  = 1'b1;
            in_sample = tbl[i].s;
            in_last   = tbl[i].last;
            step();
            chk($sformatf("tbl%0d_err", i), frame_err, tbl[i].e_err);
            chk($sformatf("tbl%0d_start", i), dp_start, tbl[i].e_start);
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_ready);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_r = 64'hEE22_0180_7F05_F010;
        chk("nom_dp_r", dp_r, exp_r);

        dp_codeword = 8'hA5;
        dp_metric   = 8'h13;
        wait_valid(k, starts);
        chk("nom_latency", k, L + 1);
        chk("nom_extra_start", starts, 0);
        chk("nom_cw", out_codeword, 8'hA5);
        chk("nom_mt", out_metric, 8'h13);

        // Backpressure: result must stay put while downstream stalls.
        for (int i = 0; i < 20; i++) begin
            dp_codeword = 8'($urandom);
            dp_metric   = 8'($urandom);
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_cw", out_codeword, 8'hA5);
            chk("bp_mt", out_metric, 8'h13);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            chk("bp_dp_r", dp_r, exp_r);
        end
        handshake();
        chk("hs_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hs_busy", busy, 0);
        chk("hs_cnt", frame_cnt, 1);

        // Missing end marker on the 8th sample: flagged but still decoded.
        dp_codeword = 8'h5A;
        dp_metric   = 8'h42;
        frame8(64'h8877_6655_4433_2211, 1'b0, errs, st);
        chk("miss_err_now", frame_err, 1);
        chk("miss_errs", errs, 1);
        chk("miss_start", st, 1);
        chk("miss_dp_r", dp_r, exp_r);
        wait_valid(k, starts);
        chk("miss_latency", k, L + 1);
        chk("miss_cw", out_codeword, 8'h5A);
        chk("miss_mt", out_metric, 8'h42);
        handshake();
        chk("miss_cnt", frame_cnt, 2);

        // Reset while waiting on the datapath.
        frame8(64'h0102_0304_0506_0708, 1'b1, errs, st);
        step();
        step();
        #2 RST_N = 1'b0;
        #1;
        chk("wrst_valid", out_valid, 0);
        chk("wrst_start", dp_start, 0);
        chk("wrst_cnt", frame_cnt, 0);
        chk("wrst_in_ready", in_ready, 1);
        chk("wrst_busy", busy, 0);
        chk("wrst_dp_r", dp_r, 0);
        chk("wrst_cw", out_codeword, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        exp_r = '0;
        dp_codeword = 8'hC3;
        dp_metric   = 8'h99;
        frame8(64'hDEAD_BEEF_CAFE_F00D, 1'b1, errs, st);
        chk("wrst2_errs", errs, 0);
        wait_valid(k, starts);
        chk("wrst2_latency", k, L + 1);
        chk("wrst2_cw", out_codeword, 8'hC3);
        handshake();
        chk("wrst2_cnt", frame_cnt, 1);

        // Back-to-back frames with continuous valid/ready.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc = 0;
        cyc = 0;
        while (vcyc.size() < 4 && cyc < 200) begin
            if (in_ready) begin
                in_sample = 8'($urandom);
                in_last   = (acc == 7);
                exp_r[acc*8 +: 8] = in_sample;
                acc = (acc + 1) % 8;
            end else begin
                in_last = 1'b0;
            end
            step();
            cyc++;
            if (out_valid) vcyc.push_back(cyc);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        step();
        out_ready = 1'b0;
        chk("b2b_count", vcyc.size(), 4);
        for (int i = 1; i < vcyc.size(); i++) begin
            chk($sformatf("b2b_period%0d", i), vcyc[i] - vcyc[i-1], FL + L + 2);
        end
        chk("b2b_cnt", frame_cnt, 5);
        chk("b2b_dp_r", dp_r, exp_r);

        // Counter wrap from 0xFFFF.
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        chk("wrap_pre", frame_cnt, 16'hFFFF);
        dp_codeword = 8'h3C;
        dp_metric   = 8'h7E;
        frame8(64'h1020_3040_5060_7080, 1'b1, errs, st);
        wait_valid(k, starts);
        chk("wrap_latency", k, L + 1);
        handshake();
        chk("wrap_cnt", frame_cnt, 0);

        // Randomized phase against the reference model.
        exp_cw = 8'h3C; exp_mt = 8'h7E; cnt = '0;
        n = 0; e = 0; t_last = 0; in_frame = 0; err_exp = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            exp_valid = (in_frame != 0) && (e >= t_last + 1 + L);
            chk("rnd_in_ready", in_ready, (in_frame == 0));
            chk("rnd_busy", busy, (in_frame != 0));
            chk("rnd_start", dp_start, (in_frame != 0) && (e == t_last));
            chk("rnd_valid", out_valid, exp_valid);
            chk("rnd_err", frame_err, err_exp);
            chk("rnd_cw", out_codeword, exp_cw);
            chk("rnd_mt", out_metric, exp_mt);
            chk("rnd_cnt", frame_cnt, cnt);
            chk("rnd_dp_r", dp_r, exp_r);

            in_valid    = ($urandom % 10) < 7;
            in_last     = ($urandom % 8) == 0;
            in_sample   = 8'($urandom);
            dp_codeword = 8'($urandom);
            dp_metric   = 8'($urandom);
            out_ready   = 1'($urandom);

            err_n = 1'b0;
            if (in_frame != 0) begin
                if (exp_valid && out_ready) begin
                    in_frame = 0;
                    cnt = cnt + 16'd1;
                end else if (e + 1 == t_last + 1 + L) begin
                    exp_cw = dp_codeword;
                    exp_mt = dp_metric;
                end
            end else if (in_valid) begin
                exp_r[n*8 +: 8] = in_sample;
                if (n == FL - 1) begin
                    err_n = !in_last;
                    t_last = e + 1;
                    in_frame = 1;
                    n = 0;
                end else if (in_last) begin
                    err_n = 1'b1;
                    n = 0;
                end else begin
                    n++;
                end
            end
            err_exp = err_n;
            e++;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
